// File: rtl/button_ctrl_if.sv
`timescale 1ns/1ps
// Key inputs and control outputs of the run/speed push-button controller.
// The design takes the slave view; the environment driving the keys takes the master view.
interface button_ctrl_if;
  logic        KEY_RUN_n;
  logic        KEY_SPEED_n;
  logic        ENABLE;
  logic [1:0]  SPEED_SEL;
  logic [21:0] MODULO;
  logic [1:0]  PRESS;

  modport slave (
    input  KEY_RUN_n,
    input  KEY_SPEED_n,
    output ENABLE,
    output SPEED_SEL,
    output MODULO,
    output PRESS
  );

  modport master (
    output KEY_RUN_n,
    output KEY_SPEED_n,
    input  ENABLE,
    input  SPEED_SEL,
    input  MODULO,
    input  PRESS
  );
endinterface

// File: rtl/button_ctrl.sv
`timescale 1ns/1ps
// Debounces a run key and a speed key, toggling a run/stop ENABLE and stepping a
// 4-entry speed index whose prescaler modulo is presented as a registered output.
module button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MOD0            = 1250000,
  parameter int unsigned MOD1            = 625000,
  parameter int unsigned MOD2            = 312500,
  parameter int unsigned MOD3            = 2500000
) (
  input  logic         CLK,
  input  logic         RSTn,
  button_ctrl_if.slave bus
);

  localparam int unsigned NKEYS   = 2;
  localparam logic [19:0] C_LAST  = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [21:0] C_MOD0  = 22'(MOD0);
  localparam logic [21:0] C_MOD1  = 22'(MOD1);
  localparam logic [21:0] C_MOD2  = 22'(MOD2);
  localparam logic [21:0] C_MOD3  = 22'(MOD3);

  typedef enum logic [1:0] {
    RELEASED,
    CONFIRM_PRESS,
    PRESSED,
    CONFIRM_RELEASE
  } deb_state_t;

  logic [NKEYS-1:0] w_key_raw;
  logic [NKEYS-1:0] r_sync1;
  logic [NKEYS-1:0] r_sync2;
  logic [NKEYS-1:0] w_accept;

  logic             r_enable;
  logic [1:0]       r_speed;
  logic [21:0]      r_modulo;
  logic [1:0]       r_press;
  logic [1:0]       w_speed_next;
  logic [21:0]      w_modulo_next;

  // Bit 0 is the run key, bit 1 the speed key; PRESS uses the same ordering.
  assign w_key_raw = {bus.KEY_SPEED_n, bus.KEY_RUN_n};

  // Synchronizers idle high so a reset looks like "key released".
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_key_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NKEYS; gi++) begin : g_key
      deb_state_t  r_state;
      deb_state_t  w_state_next;
      logic [19:0] r_cnt;
      logic [19:0] w_cnt_next;
      logic        w_acc;

      always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc        = 1'b0;
        case (r_state)
          RELEASED: begin
            if (!r_sync2[gi]) begin
              w_state_next = CONFIRM_PRESS;
              w_cnt_next   = '0;
            end
          end
          CONFIRM_PRESS: begin
            if (r_sync2[gi]) begin
              w_state_next = RELEASED;
              w_cnt_next   = '0;
            end else if (r_cnt == C_LAST) begin
              w_state_next = PRESSED;
              w_acc        = 1'b1;
            end else begin
              w_cnt_next   = r_cnt + 20'd1;
            end
          end
          PRESSED: begin
            if (r_sync2[gi]) begin
              w_state_next = CONFIRM_RELEASE;
              w_cnt_next   = '0;
            end
          end
          CONFIRM_RELEASE: begin
            // A low bounce returns to PRESSED without producing another event.
            if (!r_sync2[gi]) begin
              w_state_next = PRESSED;
            end else if (r_cnt == C_LAST) begin
              w_state_next = RELEASED;
            end else begin
              w_cnt_next   = r_cnt + 20'd1;
            end
          end
          default: begin
            w_state_next = RELEASED;
            w_cnt_next   = '0;
          end
        endcase
      end

      assign w_accept[gi] = w_acc;
    end
  endgenerate

  assign w_speed_next = 2'(r_speed + 2'd1);

  always_comb begin
    w_modulo_next = C_MOD0;
    case (w_speed_next)
      2'd0:    w_modulo_next = C_MOD0;
      2'd1:    w_modulo_next = C_MOD1;
      2'd2:    w_modulo_next = C_MOD2;
      default: w_modulo_next = C_MOD3;
    endcase
  end

  // Both keys may be accepted on the same edge; their effects are independent.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_enable <= 1'b0;
      r_speed  <= 2'd0;
      r_modulo <= C_MOD0;
      r_press  <= 2'b00;
    end else begin
      r_press <= w_accept;
      if (w_accept[0]) begin
        r_enable <= ~r_enable;
      end
      if (w_accept[1]) begin
        r_speed  <= w_speed_next;
        r_modulo <= w_modulo_next;
      end
    end
  end

  assign bus.ENABLE    = r_enable;
  assign bus.SPEED_SEL = r_speed;
  assign bus.MODULO    = r_modulo;
  assign bus.PRESS     = r_press;

endmodule

// File: tb/tb_button_ctrl.sv
`timescale 1ns/1ps
// Bench for button_ctrl with a 4-cycle debounce: accepted presses are queued as
// expectations when a key is driven low and matched against PRESS pulses.
module tb_button_ctrl;

  localparam int          DC = 4;
  localparam logic [21:0] M0 = 22'd1250000;
  localparam logic [21:0] M1 = 22'd625000;
  localparam logic [21:0] M2 = 22'd312500;
  localparam logic [21:0] M3 = 22'd2500000;

  logic CLK = 1'b0;
  logic RSTn;

  button_ctrl_if bus_if ();

  button_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  press;
    logic        en;
    logic [1:0]  spd;
    logic [21:0] modulo;
    int          at_cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc   = 0;
  int         n_vec = 0;
  int         n_err = 0;
  logic       exp_en;
  logic [1:0] exp_spd;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [21:0] mod_of(input logic [1:0] s);
    case (s)
      2'd0:    return M0;
      2'd1:    return M1;
      2'd2:    return M2;
      default: return M3;
    endcase
  endfunction

  // Every PRESS pulse must match the oldest pending expectation, including its edge.
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RSTn === 1'b1 && bus_if.PRESS !== 2'b00) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_press: PRESS=%b at cycle %0d, none pending", bus_if.PRESS, cyc);
      end else begin
        e = sb.pop_front();
        if (bus_if.PRESS !== e.press || bus_if.ENABLE !== e.en || bus_if.SPEED_SEL !== e.spd ||
            bus_if.MODULO !== e.modulo || cyc !== e.at_cyc) begin
          n_err++;
          $display("FAIL press_event: got PRESS=%b EN=%b SPD=%0d MOD=%0d cyc=%0d, want PRESS=%b EN=%b SPD=%0d MOD=%0d cyc=%0d",
                   bus_if.PRESS, bus_if.ENABLE, bus_if.SPEED_SEL, bus_if.MODULO, cyc,
                   e.press, e.en, e.spd, e.modulo, e.at_cyc);
        end else begin
          $display("press ok: PRESS=%b EN=%b SPD=%0d MOD=%0d cyc=%0d",
                   bus_if.PRESS, bus_if.ENABLE, bus_if.SPEED_SEL, bus_if.MODULO, cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    RSTn               = 1'b0;
    bus_if.KEY_RUN_n   = 1'b1;
    bus_if.KEY_SPEED_n = 1'b1;
    tick(3);
    RSTn    = 1'b1;
    exp_en  = 1'b0;
    exp_spd = 2'd0;
  endtask

  // Called on the cycle a key goes low and stays low.
  task automatic expect_press(input logic [1:0] p);
    exp_t e;
    if (p[0]) exp_en = ~exp_en;
    if (p[1]) exp_spd = 2'(exp_spd + 2'd1);
    e.press  = p;
    e.en     = exp_en;
    e.spd    = exp_spd;
    e.modulo = mod_of(exp_spd);
    e.at_cyc = cyc + DC + 3;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    RSTn               = 1'b0;
    bus_if.KEY_RUN_n   = 1'b1;
    bus_if.KEY_SPEED_n = 1'b1;
    tick(3);
    n_vec++;
    if (bus_if.ENABLE !== 1'b0) begin
      n_err++; $display("FAIL reset_enable: got %b want 0", bus_if.ENABLE);
    end
    n_vec++;
    if (bus_if.SPEED_SEL !== 2'd0) begin
      n_err++; $display("FAIL reset_speed: got %0d want 0", bus_if.SPEED_SEL);
    end
    n_vec++;
    if (bus_if.MODULO !== M0) begin
      n_err++; $display("FAIL reset_modulo: got %0d want %0d", bus_if.MODULO, M0);
    end
    n_vec++;
    if (bus_if.PRESS !== 2'b00) begin
      n_err++; $display("FAIL reset_press: got %b want 00", bus_if.PRESS);
    end
    $display("test_reset done");
  endtask

  task automatic test_run_hold();
    do_reset();
    bus_if.KEY_RUN_n = 1'b0;
    expect_press(2'b01);
    tick(DC + 2);
    n_vec++;
    if (bus_if.ENABLE !== 1'b0) begin
      n_err++; $display("FAIL run_early: ENABLE got %b want 0 before accept edge", bus_if.ENABLE);
    end
    tick(30);
    n_vec++;
    if (bus_if.ENABLE !== 1'b1 || sb.size() != 0) begin
      n_err++; $display("FAIL run_hold: ENABLE got %b want 1, pending %0d want 0", bus_if.ENABLE, sb.size());
    end
    bus_if.KEY_RUN_n = 1'b1;
    tick(12);
    $display("test_run_hold done");
  endtask

  task automatic test_glitch();
    for (int w = 1; w <= DC; w++) begin
      bus_if.KEY_RUN_n = 1'b0;
      tick(w);
      bus_if.KEY_RUN_n = 1'b1;
      tick(10);
      bus_if.KEY_SPEED_n = 1'b0;
      tick(w);
      bus_if.KEY_SPEED_n = 1'b1;
      tick(10);
      n_vec++;
      if (bus_if.ENABLE !== exp_en || bus_if.SPEED_SEL !== exp_spd) begin
        n_err++;
        $display("FAIL glitch_w%0d: EN=%b SPD=%0d want EN=%b SPD=%0d", w,
                 bus_if.ENABLE, bus_if.SPEED_SEL, exp_en, exp_spd);
      end
    end
    $display("test_glitch done");
  endtask

  task automatic test_speed();
    for (int i = 0; i < 5; i++) begin
      bus_if.KEY_SPEED_n = 1'b0;
      expect_press(2'b10);
      tick(10);
      n_vec++;
      if (bus_if.SPEED_SEL !== exp_spd || bus_if.MODULO !== mod_of(exp_spd)) begin
        n_err++;
        $display("FAIL speed_%0d: SPD=%0d MOD=%0d want SPD=%0d MOD=%0d", i,
                 bus_if.SPEED_SEL, bus_if.MODULO, exp_spd, mod_of(exp_spd));
      end
      bus_if.KEY_SPEED_n = 1'b1;
      tick(10);
    end
    $display("test_speed done");
  endtask

  task automatic test_bounce_release();
    do_reset();
    bus_if.KEY_RUN_n = 1'b0;
    expect_press(2'b01);
    tick(10);
    for (int b = 0; b < 3; b++) begin
      bus_if.KEY_RUN_n = 1'b1;
      tick(2);
      bus_if.KEY_RUN_n = 1'b0;
      tick(2);
    end
    bus_if.KEY_RUN_n = 1'b1;
    tick(12);
    n_vec++;
    if (bus_if.ENABLE !== 1'b1) begin
      n_err++; $display("FAIL bounce_first: ENABLE got %b want 1", bus_if.ENABLE);
    end
    bus_if.KEY_RUN_n = 1'b0;
    expect_press(2'b01);
    tick(10);
    bus_if.KEY_RUN_n = 1'b1;
    tick(12);
    n_vec++;
    if (bus_if.ENABLE !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL bounce_second: ENABLE got %b want 0, pending %0d want 0", bus_if.ENABLE, sb.size());
    end
    $display("test_bounce_release done");
  endtask

  task automatic test_simultaneous();
    bus_if.KEY_RUN_n   = 1'b0;
    bus_if.KEY_SPEED_n = 1'b0;
    expect_press(2'b11);
    tick(10);
    n_vec++;
    if (bus_if.ENABLE !== exp_en || bus_if.SPEED_SEL !== exp_spd) begin
      n_err++;
      $display("FAIL simultaneous: EN=%b SPD=%0d want EN=%b SPD=%0d",
               bus_if.ENABLE, bus_if.SPEED_SEL, exp_en, exp_spd);
    end
    bus_if.KEY_RUN_n   = 1'b1;
    bus_if.KEY_SPEED_n = 1'b1;
    tick(12);
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    bus_if.KEY_RUN_n = 1'b0;
    tick(5);
    RSTn = 1'b0;
    #1;
    n_vec++;
    if (bus_if.ENABLE !== 1'b0 || bus_if.MODULO !== M0 || bus_if.SPEED_SEL !== 2'd0 || bus_if.PRESS !== 2'b00) begin
      n_err++;
      $display("FAIL async_reset: EN=%b MOD=%0d SPD=%0d PRESS=%b want 0 %0d 0 00",
               bus_if.ENABLE, bus_if.MODULO, bus_if.SPEED_SEL, bus_if.PRESS, M0);
    end
    exp_en  = 1'b0;
    exp_spd = 2'd0;
    tick(2);
    RSTn = 1'b1;
    expect_press(2'b01);
    tick(DC);
    n_vec++;
    if (bus_if.ENABLE !== 1'b0) begin
      n_err++; $display("FAIL reset_discard: ENABLE got %b want 0 while re-debouncing", bus_if.ENABLE);
    end
    tick(10);
    n_vec++;
    if (bus_if.ENABLE !== 1'b1) begin
      n_err++; $display("FAIL reset_new_press: ENABLE got %b want 1", bus_if.ENABLE);
    end
    bus_if.KEY_RUN_n = 1'b1;
    tick(12);
    $display("test_reset_mid done");
  endtask

  initial begin
    exp_en  = 1'b0;
    exp_spd = 2'd0;
    test_reset();
    test_run_hold();
    test_glitch();
    test_speed();
    test_bounce_release();
    test_simultaneous();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL missing_press: %0d expected presses never seen", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
